// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
package pc_fetch_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: jump beats branch beats sequential, plus redirect and
// misalignment flags for the selected redirect target.
module next_pc_sel
  import pc_fetch_pkg::*;
(
  input  logic              jump,
  input  logic [WORD_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic [WORD_W-1:0] seq_pc,
  output logic              redirect,
  output logic [WORD_W-1:0] next_pc,
  output logic              misaligned
);

  // Priority mux and word-alignment check on the chosen target.
  always_comb begin
    redirect   = jump | branch_taken;
    next_pc    = jump ? jump_target : (branch_taken ? branch_target : seq_pc);
    misaligned = redirect && (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch sequencer feeding decode.
//
// Memory handshake: imem_req is high only in FETCH, with imem_addr = pc held
// stable until imem_ready. A cycle with imem_req && imem_ready completes the
// transfer and imem_rdata is valid in that cycle only. Decode side: an
// instruction is accepted in any cycle with instr_valid && !stall.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              jump,
  input  logic [WORD_W-1:0] jump_target,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              addr_err
);

  state_t            state, state_d;
  logic [WORD_W-1:0] pc, pc_d, seq_pc, sel_pc;
  logic              redirect, misaligned;
  logic              pend_valid;
  logic [WORD_W-1:0] pend_target;

  // Control strobes from the sequencer to the datapath registers.
  logic capture, valid_clr, pc_we, pend_we, pend_clr, err_set;

  assign seq_pc    = pc + 32'd4;
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  next_pc_sel u_next_pc_sel (
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .seq_pc        (seq_pc),
    .redirect      (redirect),
    .next_pc       (sel_pc),
    .misaligned    (misaligned)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and datapath control. Redirects take precedence over stall
  // and over a returning word; a word returning while the presented
  // instruction is still stalled is dropped and refetched after the stall.
  always_comb begin
    state_d   = state;
    pc_d      = sel_pc;
    capture   = 1'b0;
    valid_clr = 1'b0;
    pc_we     = 1'b0;
    pend_we   = 1'b0;
    pend_clr  = 1'b0;
    err_set   = 1'b0;
    if (state != HALT && redirect) begin
      valid_clr = 1'b1;
      if (misaligned) begin
        err_set  = 1'b1;
        pend_clr = 1'b1;
        state_d  = HALT;
      end else if (state == FETCH && !imem_ready) begin
        pend_we = 1'b1;
      end else begin
        pc_we    = 1'b1;
        pend_clr = 1'b1;
        state_d  = FETCH;
      end
    end else begin
      case (state)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem_ready) begin
            if (pend_valid) begin
              pc_we     = 1'b1;
              pc_d      = pend_target;
              pend_clr  = 1'b1;
              valid_clr = 1'b1;
            end else if (instr_valid && stall) begin
              state_d = HOLD;
            end else begin
              capture = 1'b1;
              pc_we   = 1'b1;
              state_d = stall ? HOLD : FETCH;
            end
          end else if (instr_valid && !stall) begin
            valid_clr = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_clr = 1'b1;
            state_d   = FETCH;
          end
        end
        HALT:    valid_clr = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath registers: PC, presented instruction, pending redirect, error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      pc_out      <= '0;
      pc_plus4    <= '0;
      instr_valid <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      addr_err    <= 1'b0;
    end else begin
      if (pc_we) pc <= pc_d;
      if (capture) begin
        instr       <= imem_rdata;
        pc_out      <= pc;
        pc_plus4    <= seq_pc;
        instr_valid <= 1'b1;
      end else if (valid_clr) begin
        instr_valid <= 1'b0;
      end
      if (pend_we) begin
        pend_valid  <= 1'b1;
        pend_target <= sel_pc;
      end else if (pend_clr) begin
        pend_valid  <= 1'b0;
      end
      if (err_set) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, addr_err;
  logic [31:0] instr, pc_out, pc_plus4;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Clock.
  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .addr_err      (addr_err)
  );

  // Instruction memory content: a fixed address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},    {31'd0, imem_req},    32'd0);
    chk({tag, "_addr"},   imem_addr,            32'h0);
    chk({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"},  instr,                32'h0);
    chk({tag, "_pcout"},  pc_out,               32'h0);
    chk({tag, "_pcp4"},   pc_plus4,             32'h0);
    chk({tag, "_err"},    {31'd0, addr_err},    32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0; imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // 1: sequential fetch with ready tied high.
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("f0_req", {31'd0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'h0);
    chk("f0_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_valid", {31'd0, instr_valid}, 32'd1);
    chk("f1_pcout", pc_out, 32'h0);
    chk("f1_pcp4", pc_plus4, 32'h4);
    chk("f1_instr", instr, mem_word(32'h0));
    tick();
    chk("f2_addr", imem_addr, 32'h8);
    chk("f2_pcout", pc_out, 32'h4);
    tick();
    chk("f3_addr", imem_addr, 32'hC);
    chk("f3_pcout", pc_out, 32'h8);
    chk("f3_pcp4", pc_plus4, 32'hC);

    // 2: three wait cycles on address 0xC.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w_req", {31'd0, imem_req}, 32'd1);
      chk("w_addr", imem_addr, 32'hC);
      chk("w_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    chk("w_done_valid", {31'd0, instr_valid}, 32'd1);
    chk("w_done_pcout", pc_out, 32'hC);
    chk("w_done_instr", instr, mem_word(32'hC));
    chk("w_done_addr", imem_addr, 32'h10);

    // 3: two stall cycles hold the presented instruction.
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_req", {31'd0, imem_req}, 32'd0);
      chk("st_valid", {31'd0, instr_valid}, 32'd1);
      chk("st_pcout", pc_out, 32'hC);
      chk("st_instr", instr, mem_word(32'hC));
    end
    stall = 1'b0;
    tick();
    chk("st_rel_req", {31'd0, imem_req}, 32'd1);
    chk("st_rel_addr", imem_addr, 32'h10);
    chk("st_rel_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("st_cap_pcout", pc_out, 32'h10);
    chk("st_cap_addr", imem_addr, 32'h14);

    // 4: two redirects while the fetch of 0x14 is outstanding.
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    chk("br_valid", {31'd0, instr_valid}, 32'd0);
    chk("br_addr_held", imem_addr, 32'h14);
    branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h80;
    tick();
    chk("jp_addr_held", imem_addr, 32'h14);
    jump = 1'b0; imem_ready = 1'b1;
    tick();
    chk("pend_discard_valid", {31'd0, instr_valid}, 32'd0);
    chk("pend_addr", imem_addr, 32'h80);
    chk("pend_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("pend_cap_pcout", pc_out, 32'h80);
    chk("pend_cap_instr", instr, mem_word(32'h80));

    // 5: jump and branch together under stall; jump wins, stall loses.
    stall = 1'b1; jump = 1'b1; jump_target = 32'h100;
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    chk("jb_valid", {31'd0, instr_valid}, 32'd0);
    chk("jb_addr", imem_addr, 32'h100);
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    tick();
    chk("jb_cap_pcout", pc_out, 32'h100);

    // Wrap-around at the top of the address space.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    jump = 1'b0;
    tick();
    chk("wrap_pcout", pc_out, 32'hFFFF_FFFC);
    chk("wrap_pcp4", pc_plus4, 32'h0);
    chk("wrap_addr_next", imem_addr, 32'h0);
    chk("wrap_err", {31'd0, addr_err}, 32'd0);

    // 6: misaligned jump halts fetch with a sticky error.
    imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h102;
    tick();
    chk("mis_err", {31'd0, addr_err}, 32'd1);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    jump = 1'b0; imem_ready = 1'b1;
    repeat (2) tick();
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_err", {31'd0, addr_err}, 32'd1);

    // Asynchronous reset out of HALT.
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("arst1");
    #1 rst_n = 1'b1;
    chk("arst1_idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);

    // Asynchronous reset in the middle of an outstanding fetch.
    imem_ready = 1'b0;
    tick();
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("arst2_req", {31'd0, imem_req}, 32'd0);
    #1 rst_n = 1'b1;
    imem_ready = 1'b1;
    tick();
    chk("arst2_fetch_addr", imem_addr, 32'h0);
    tick();
    chk("arst2_cap_pcout", pc_out, 32'h0);
    chk("arst2_cap_instr", instr, mem_word(32'h0));
    chk("arst2_cap_valid", {31'd0, instr_valid}, 32'd1);
    chk("arst2_next_addr", imem_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
